// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection.
//            Inserts a single bubble on a load-use hazard and squashes the
//            stage on a downstream branch-taken flush.
// Option   : define ID_EX_BUBBLE_COUNT_EN to add a saturating 16-bit
//            bubble_count output (bubbles caused by stall or flush).
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ctl_ex,
  input  logic [2:0]  ctl_m,
  input  logic [1:0]  ctl_wb,
  input  logic        id_valid,
  input  logic [31:0] id_npc,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  output logic [3:0]  ex_ex,
  output logic [2:0]  ex_m,
  output logic [1:0]  ex_wb,
  output logic        ex_valid,
  output logic [31:0] ex_npc,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [15:0] bubble_count,
`endif
  output logic        stall
);

  // Stage occupancy: VALID holds a real instruction, BUBBLE holds a no-op.
  typedef enum logic [0:0] {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } stage_state_t;

  stage_state_t state_q, state_d;

  logic [3:0]  ex_ex_q,  ex_ex_d;
  logic [2:0]  ex_m_q,   ex_m_d;
  logic [1:0]  ex_wb_q,  ex_wb_d;
  logic [31:0] ex_npc_q, ex_npc_d;
  logic [31:0] ex_rd1_q, ex_rd1_d;
  logic [31:0] ex_rd2_q, ex_rd2_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rt_q,  ex_rt_d;
  logic [4:0]  ex_rd_q,  ex_rd_d;

  logic hazard;
  logic bubble;
  logic load_valid;

  // Load-use hazard: the load in EX writes a register the decode slot reads.
  // Depends only on registered state and id_* inputs, never on flush.
  always_comb begin
    hazard = 1'b0;
    if (state_q == ST_VALID && ex_m_q[1] && id_valid && (ex_rt_q != 5'd0) &&
        ((ex_rt_q == id_rs) || (ex_rt_q == id_rt))) begin
      hazard = 1'b1;
    end
  end

  // Next-state and next-register values; controls are zeroed on any bubble.
  always_comb begin
    bubble     = flush | hazard;
    load_valid = id_valid & ~bubble;
    state_d    = load_valid ? ST_VALID : ST_BUBBLE;
    // Control passes straight through (including x bits) on a real load.
    ex_ex_d    = load_valid ? ctl_ex : 4'd0;
    ex_m_d     = load_valid ? ctl_m  : 3'd0;
    ex_wb_d    = load_valid ? ctl_wb : 2'd0;
    // Datapath always loads; its value is irrelevant behind a bubble.
    ex_npc_d   = id_npc;
    ex_rd1_d   = id_rd1;
    ex_rd2_d   = id_rd2;
    ex_imm_d   = id_imm;
    ex_rt_d    = id_rt;
    ex_rd_d    = id_rd;
  end

  // Pipeline register with synchronous reset to a known empty stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BUBBLE;
      ex_ex_q  <= 4'd0;
      ex_m_q   <= 3'd0;
      ex_wb_q  <= 2'd0;
      ex_npc_q <= 32'd0;
      ex_rd1_q <= 32'd0;
      ex_rd2_q <= 32'd0;
      ex_imm_q <= 32'd0;
      ex_rt_q  <= 5'd0;
      ex_rd_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      ex_ex_q  <= ex_ex_d;
      ex_m_q   <= ex_m_d;
      ex_wb_q  <= ex_wb_d;
      ex_npc_q <= ex_npc_d;
      ex_rd1_q <= ex_rd1_d;
      ex_rd2_q <= ex_rd2_d;
      ex_imm_q <= ex_imm_d;
      ex_rt_q  <= ex_rt_d;
      ex_rd_q  <= ex_rd_d;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubble_count_q, bubble_count_d;

  // Saturating count of bubbles inserted by stall or flush.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (bubble && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  // Counter register, cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_q <= 16'd0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

  assign ex_valid = (state_q == ST_VALID);
  assign ex_ex    = ex_ex_q;
  assign ex_m     = ex_m_q;
  assign ex_wb    = ex_wb_q;
  assign ex_npc   = ex_npc_q;
  assign ex_rd1   = ex_rd1_q;
  assign ex_rd2   = ex_rd2_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rt    = ex_rt_q;
  assign ex_rd    = ex_rd_q;
  assign stall    = hazard;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 clk  input  1  stage clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ctl_ex  input  4  decode control {RegDst, ALUOp[1:0], ALUSrc}.
REQ-005 ctl_m  input  3  decode control {Branch, MemRead, MemWrite}.
REQ-006 ctl_wb  input  2  decode control {RegWrite, MemToReg}.
REQ-007 id_valid  input  1  decode slot holds a real instruction.
REQ-008 id_npc, id_rd1, id_rd2, id_imm  input  32 each  next PC, register reads, sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  input  5 each  decode register specifiers.
REQ-010 flush  input  1  branch-taken squash from downstream.
REQ-011 ex_ex, ex_m, ex_wb, ex_valid  output  4/3/2/1  registered control bundle and valid.
REQ-012 ex_npc, ex_rd1, ex_rd2, ex_imm  output  32 each  registered datapath fields.
REQ-013 ex_rt, ex_rd  output  5 each  registered specifiers.
REQ-014 stall  output  1  combinational load-use hazard; holds PC and IF/ID upstream.

Function
REQ-015 Load: with no flush and no stall, all ex_* outputs SHALL take their id_* / ctl_* inputs at the next edge (latency 1 cycle).
REQ-016 Hazard: stall SHALL be 1 iff ex_valid & ex_m[1] & id_valid & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt); otherwise 0.
REQ-017 Bubble: when stall=1 and flush=0, next edge SHALL load ex_ex=0, ex_m=0, ex_wb=0, ex_valid=0; datapath fields SHALL also load from inputs (don't-care).
REQ-018 Bubble duration: a load-use hazard SHALL produce exactly one bubble, since the bubble clears ex_m[1] and stall deasserts the following cycle.
REQ-019 Flush: flush=1 SHALL force the bubble values of REQ-017 at the next edge regardless of stall or id_valid.
REQ-020 Priority per edge: rst > flush > stall > load.
REQ-021 id_valid=0 with no flush/stall SHALL load zero control bundles and ex_valid=0.
REQ-022 Don't-care (x) bits in ctl_* SHALL pass through unmodified on a normal load; bubble/flush/reset SHALL always produce known zeros.
REQ-023 stall SHALL depend only on registered state and current id_* inputs; it SHALL NOT depend on flush.
REQ-024 Stage state machine per edge: VALID (ex_valid=1) and BUBBLE (ex_valid=0); any state -> VALID on load with id_valid=1; any state -> BUBBLE on rst, flush, stall, or id_valid=0.

Reset
REQ-025 rst=1 at an edge SHALL clear every ex_* output to 0 and ex_valid to 0; stall SHALL therefore read 0 the cycle after reset.
REQ-026 rst asserted mid-hazard SHALL override the pending bubble; no stale stall SHALL survive reset.
REQ-027 Before the first reset edge outputs are undefined; the bench SHALL apply rst for at least 2 cycles.

Configuration
REQ-028 Macro ID_EX_BUBBLE_COUNT_EN: when defined, the block SHALL add output bubble_count (16 bits) counting edges at which a bubble was inserted by stall or flush (not reset); it SHALL clear on rst and saturate at 16'hFFFF.
REQ-029 Without ID_EX_BUBBLE_COUNT_EN the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 R-type load: ctl_ex=1100, ctl_m=000, ctl_wb=10, id_valid=1, id_rd1=32'h11 -> next cycle ex_ex=1100, ex_wb=10, ex_rd1=32'h11, ex_valid=1, stall=0.
REQ-031 Load-use: LW (ctl_m=010, id_rt=5) loaded, then id_rs=5 -> stall=1 that cycle; next edge ex_m=000, ex_valid=0; stall=0 after; bubble_count=1 when enabled.
REQ-032 No false hazard: LW with id_rt=0 followed by id_rs=0 -> stall=0; LW id_rt=5 followed by SW (ctl_m=001) reading rs=6, rt=7 -> stall=0.
REQ-033 Flush beats stall: flush=1 during stall=1 with valid RTYPE at input -> next edge all ex_* controls 0, ex_valid=0; bubble_count increments by exactly 1.
REQ-034 Reset mid-operation: rst=1 while ex_m=010 and stall=1 -> next edge all outputs 0, stall=0, bubble_count=0.
REQ-035 Saturation (macro on): force 65 536 consecutive flushes -> bubble_count holds 16'hFFFF.
